instruction_decoder: RTL and testbench

- Upstream of the microsequencer. Pops instruction bytes from the prefetch queue, one byte per cycle.
- Parses segment prefix, opcode, ModRM, displacement and immediate.
- Presents one fully decoded instruction on registered outputs: opcode, operands, mod/rm, imm, disp, EA registers and segment.
- Outputs are held until the microsequencer accepts them; a flush (branch, reset) discards partial decode.

---
 rtl/instruction_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_instruction_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// ============================================================================
// instruction_decoder: pops prefetch bytes and presents one decoded instruction
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        queue_valid,
  input  logic [7:0]  queue_byte,
  output logic        queue_pop,
  output logic        decode_valid,
  input  logic        accept,
  output logic [7:0]  opcode,
  output logic        word,
  output logic [3:0]  src_operand,
  output logic [3:0]  dst_operand,
  output logic [1:0]  mod,
  output logic [2:0]  rm,
  output logic [15:0] imm,
  output logic        imm_size,
  output logic [15:0] disp,
  output logic        disp_size,
  output logic [3:0]  ea_base_reg,
  output logic [3:0]  ea_index_reg,
  output logic [1:0]  ea_segment_reg,
  output logic [3:0]  length
);

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_MODRM   = 3'd1,
    S_DISP_LO = 3'd2,
    S_DISP_HI = 3'd3,
    S_IMM_LO  = 3'd4,
    S_IMM_HI  = 3'd5,
    S_VALID   = 3'd6
  } state_t;

  localparam logic [3:0] OPND_MEM  = 4'b1000;
  localparam logic [3:0] OPND_IMM  = 4'b1001;
  localparam logic [3:0] OPND_NONE = 4'b1111;
  localparam logic [3:0] REG_NONE  = 4'b1000;
  localparam logic [3:0] REG_BW    = 4'd3;
  localparam logic [3:0] REG_BP    = 4'd5;
  localparam logic [3:0] REG_IX    = 4'd6;
  localparam logic [3:0] REG_IY    = 4'd7;

  state_t state, state_next;

  logic       ovr_valid;
  logic [1:0] ovr_seg;
  logic       has_imm;

  // Opcode classification of the byte currently offered by the queue
  logic is_prefix, is_alu_rm, is_mov_rm, is_alu_imm, is_mov_imm, is_grp_imm, op_modrm;
  assign is_prefix  = (queue_byte[7:5] == 3'b001) && (queue_byte[2:0] == 3'b110);
  assign is_alu_rm  = (queue_byte[7:6] == 2'b00) && !queue_byte[2];
  assign is_mov_rm  = (queue_byte[7:2] == 6'b100010);
  assign is_alu_imm = (queue_byte[7:6] == 2'b00) && (queue_byte[2:1] == 2'b10);
  assign is_mov_imm = (queue_byte[7:4] == 4'hB);
  assign is_grp_imm = (queue_byte[7:1] == 7'b1100011) || (queue_byte[7:2] == 6'b100000);
  assign op_modrm   = is_alu_rm || is_mov_rm || is_grp_imm;

  // ModRM interpretation of the same byte
  logic [1:0] m_mod;
  logic [2:0] m_rm;
  logic [3:0] m_reg, m_rmop, m_base, m_index;
  logic [1:0] m_seg;
  logic       m_mem, m_direct, m_disp_any, m_disp_wide;
  assign m_mod       = queue_byte[7:6];
  assign m_rm        = queue_byte[2:0];
  assign m_reg       = {1'b0, queue_byte[5:3]};
  assign m_mem       = (m_mod != 2'b11);
  assign m_direct    = (m_mod == 2'b00) && (m_rm == 3'b110);
  assign m_rmop      = m_mem ? OPND_MEM : {1'b0, m_rm};
  assign m_disp_any  = (m_mod == 2'b01) || (m_mod == 2'b10) || m_direct;
  assign m_disp_wide = (m_mod == 2'b10) || m_direct;

  always_comb begin
    m_base  = REG_NONE;
    m_index = REG_NONE;
    if (m_mem && !m_direct) begin
      case (m_rm)
        3'b000:  begin m_base = REG_BW; m_index = REG_IX; end
        3'b001:  begin m_base = REG_BW; m_index = REG_IY; end
        3'b010:  begin m_base = REG_BP; m_index = REG_IX; end
        3'b011:  begin m_base = REG_BP; m_index = REG_IY; end
        3'b100:  m_index = REG_IX;
        3'b101:  m_index = REG_IY;
        3'b110:  m_base = REG_BP;
        default: m_base = REG_BW;
      endcase
    end
  end

  assign m_seg = ovr_valid ? ovr_seg : ((m_base == REG_BP) ? 2'd2 : 2'd3);

  logic [3:0] length_inc;
  assign length_inc   = (length == 4'hF) ? 4'hF : length + 4'd1;
  assign decode_valid = (state == S_VALID);

  always_comb begin
    state_next = state;
    queue_pop  = queue_valid && !flush && (state != S_VALID);
    case (state)
      S_OPCODE: if (queue_pop && !is_prefix) begin
        if (op_modrm)                      state_next = S_MODRM;
        else if (is_alu_imm || is_mov_imm) state_next = S_IMM_LO;
        else                               state_next = S_VALID;
      end
      S_MODRM: if (queue_pop) begin
        if (m_disp_any)   state_next = S_DISP_LO;
        else if (has_imm) state_next = S_IMM_LO;
        else              state_next = S_VALID;
      end
      S_DISP_LO: if (queue_pop) begin
        if (disp_size)    state_next = S_DISP_HI;
        else if (has_imm) state_next = S_IMM_LO;
        else              state_next = S_VALID;
      end
      S_DISP_HI: if (queue_pop) state_next = has_imm ? S_IMM_LO : S_VALID;
      S_IMM_LO:  if (queue_pop) state_next = imm_size ? S_IMM_HI : S_VALID;
      S_IMM_HI:  if (queue_pop) state_next = S_VALID;
      S_VALID:   if (accept) state_next = S_OPCODE;
      default:   state_next = S_OPCODE;
    endcase
    if (flush) state_next = S_OPCODE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_OPCODE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ovr_valid      <= 1'b0;
      ovr_seg        <= 2'd0;
      has_imm        <= 1'b0;
      length         <= 4'd0;
      opcode         <= 8'h00;
      word           <= 1'b0;
      src_operand    <= OPND_NONE;
      dst_operand    <= OPND_NONE;
      mod            <= 2'd0;
      rm             <= 3'd0;
      imm            <= 16'h0000;
      imm_size       <= 1'b0;
      disp           <= 16'h0000;
      disp_size      <= 1'b0;
      ea_base_reg    <= REG_NONE;
      ea_index_reg   <= REG_NONE;
      ea_segment_reg <= 2'd3;
    end else begin
      case (state)
        S_OPCODE: if (queue_pop) begin
          length <= length_inc;
          if (is_prefix) begin
            ovr_valid <= 1'b1;
            ovr_seg   <= queue_byte[4:3];
          end else begin
            // Fresh instruction: every field restarts from its idle value
            opcode         <= queue_byte;
            word           <= is_mov_imm ? queue_byte[3] : queue_byte[0];
            src_operand    <= OPND_NONE;
            dst_operand    <= OPND_NONE;
            mod            <= 2'd0;
            rm             <= 3'd0;
            imm            <= 16'h0000;
            imm_size       <= 1'b0;
            disp           <= 16'h0000;
            disp_size      <= 1'b0;
            ea_base_reg    <= REG_NONE;
            ea_index_reg   <= REG_NONE;
            ea_segment_reg <= ovr_valid ? ovr_seg : 2'd3;
            has_imm        <= is_alu_imm || is_mov_imm || is_grp_imm;
            if (is_alu_imm) begin
              src_operand <= OPND_IMM;
              dst_operand <= 4'b0000;
              imm_size    <= queue_byte[0];
            end else if (is_mov_imm) begin
              src_operand <= OPND_IMM;
              dst_operand <= {1'b0, queue_byte[2:0]};
              imm_size    <= queue_byte[3];
            end else if (is_grp_imm) begin
              imm_size <= (queue_byte == 8'hC7) || (queue_byte == 8'h81);
            end
          end
        end
        S_MODRM: if (queue_pop) begin
          length         <= length_inc;
          mod            <= m_mod;
          rm             <= m_rm;
          disp_size      <= m_disp_wide;
          ea_base_reg    <= m_base;
          ea_index_reg   <= m_index;
          ea_segment_reg <= m_seg;
          // Immediate forms always write r/m; otherwise opcode bit 1 picks direction
          if (has_imm) begin
            src_operand <= OPND_IMM;
            dst_operand <= m_rmop;
          end else if (opcode[1]) begin
            src_operand <= m_rmop;
            dst_operand <= m_reg;
          end else begin
            src_operand <= m_reg;
            dst_operand <= m_rmop;
          end
        end
        S_DISP_LO: if (queue_pop) begin
          length     <= length_inc;
          disp[7:0]  <= queue_byte;
        end
        S_DISP_HI: if (queue_pop) begin
          length     <= length_inc;
          disp[15:8] <= queue_byte;
        end
        S_IMM_LO: if (queue_pop) begin
          length    <= length_inc;
          imm[7:0]  <= queue_byte;
        end
        S_IMM_HI: if (queue_pop) begin
          length    <= length_inc;
          imm[15:8] <= queue_byte;
        end
        S_VALID: if (accept) begin
          ovr_valid <= 1'b0;
          length    <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_decoder.sv
// ============================================================================
// tb_instruction_decoder: directed vectors checked against a byte-stream decode model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset, flush, queue_valid, accept;
  logic [7:0]  queue_byte;
  logic        queue_pop, decode_valid;
  logic [7:0]  opcode;
  logic        word, imm_size, disp_size;
  logic [3:0]  src_operand, dst_operand, ea_base_reg, ea_index_reg, length;
  logic [1:0]  mod, ea_segment_reg;
  logic [2:0]  rm;
  logic [15:0] imm, disp;

  instruction_decoder dut (
    .clk(clk), .reset(reset), .flush(flush), .queue_valid(queue_valid),
    .queue_byte(queue_byte), .queue_pop(queue_pop), .decode_valid(decode_valid),
    .accept(accept), .opcode(opcode), .word(word), .src_operand(src_operand),
    .dst_operand(dst_operand), .mod(mod), .rm(rm), .imm(imm), .imm_size(imm_size),
    .disp(disp), .disp_size(disp_size), .ea_base_reg(ea_base_reg),
    .ea_index_reg(ea_index_reg), .ea_segment_reg(ea_segment_reg), .length(length)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  opcode;
    logic        word;
    logic [3:0]  src, dst;
    logic [1:0]  mod;
    logic [2:0]  rm;
    logic [15:0] imm;
    logic        imm_size;
    logic [15:0] disp;
    logic        disp_size;
    logic [3:0]  base, index;
    logic [1:0]  seg;
    logic [3:0]  length;
    int          nbytes;
  } dec_t;

  int   checks = 0;
  int   failures = 0;
  dec_t exp;
  bit   exp_armed = 0;
  logic [7:0] feed[$];
  bit   stall = 0;
  bit   popped;
  int   cyc = 0, last_pop_cyc = 0, npop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Walks the byte list the way an assembler listing reads: prefixes, opcode, ModRM, disp, imm
  function automatic dec_t model(input logic [7:0] b[$]);
    dec_t d;
    int i = 0, ovr = -1, ndisp = 0, nimm = 0;
    bit has_modrm = 0, rm_is_dst = 1, imm_src = 0;
    logic [7:0] op, m;
    logic [3:0] regop, rmop;
    while (b[i] == 8'h26 || b[i] == 8'h2E || b[i] == 8'h36 || b[i] == 8'h3E) begin
      case (b[i])
        8'h26:   ovr = 0;
        8'h2E:   ovr = 1;
        8'h36:   ovr = 2;
        default: ovr = 3;
      endcase
      i++;
    end
    op = b[i]; i++;
    d.opcode = op; d.word = op[0]; d.src = 4'hF; d.dst = 4'hF; d.mod = 0; d.rm = 0;
    d.imm = 0; d.imm_size = 0; d.disp = 0; d.disp_size = 0; d.base = 8; d.index = 8;
    d.seg = (ovr >= 0) ? 2'(ovr) : 2'd3;
    if ((op <= 8'h3F && op[2] == 1'b0) || (op >= 8'h88 && op <= 8'h8B)) begin
      has_modrm = 1; rm_is_dst = !op[1];
    end else if (op <= 8'h3F && op[2:1] == 2'b10) begin
      d.src = 9; d.dst = 0; nimm = op[0] ? 2 : 1;
    end else if (op >= 8'hB0 && op <= 8'hBF) begin
      d.src = 9; d.dst = {1'b0, op[2:0]}; d.word = op[3]; nimm = op[3] ? 2 : 1;
    end else if (op == 8'hC6 || op == 8'hC7 || (op >= 8'h80 && op <= 8'h83)) begin
      has_modrm = 1; imm_src = 1; nimm = (op == 8'hC7 || op == 8'h81) ? 2 : 1;
    end
    if (has_modrm) begin
      m = b[i]; i++;
      d.mod = m[7:6]; d.rm = m[2:0];
      regop = {1'b0, m[5:3]};
      if (d.mod == 3) rmop = {1'b0, d.rm};
      else begin
        rmop = 8;
        if (!(d.mod == 0 && d.rm == 6)) begin
          case (d.rm)
            0: begin d.base = 3; d.index = 6; end
            1: begin d.base = 3; d.index = 7; end
            2: begin d.base = 5; d.index = 6; end
            3: begin d.base = 5; d.index = 7; end
            4: d.index = 6;
            5: d.index = 7;
            6: d.base = 5;
            default: d.base = 3;
          endcase
        end
        if (d.mod == 1) ndisp = 1;
        else if (d.mod == 2 || d.rm == 6) ndisp = 2;
        if (ovr < 0) d.seg = (d.base == 5) ? 2'd2 : 2'd3;
      end
      if (imm_src) begin d.dst = rmop; d.src = 9; end
      else if (rm_is_dst) begin d.src = regop; d.dst = rmop; end
      else begin d.src = rmop; d.dst = regop; end
    end
    if (ndisp >= 1) begin d.disp[7:0] = b[i]; i++; end
    if (ndisp == 2) begin d.disp[15:8] = b[i]; i++; end
    d.disp_size = (ndisp == 2);
    if (nimm >= 1) begin d.imm[7:0] = b[i]; i++; end
    if (nimm == 2) begin d.imm[15:8] = b[i]; i++; end
    d.imm_size = (nimm == 2);
    d.nbytes = i;
    d.length = (i > 15) ? 4'd15 : 4'(i);
    return d;
  endfunction

  always @(negedge clk) begin
    if (!reset && decode_valid) begin
      if (!exp_armed) check("spurious_valid", 32'(decode_valid), 0);
      else begin
        check("opcode", 32'(opcode), 32'(exp.opcode));
        check("word", 32'(word), 32'(exp.word));
        check("src", 32'(src_operand), 32'(exp.src));
        check("dst", 32'(dst_operand), 32'(exp.dst));
        check("mod", 32'(mod), 32'(exp.mod));
        check("rm", 32'(rm), 32'(exp.rm));
        check("imm", 32'(imm), 32'(exp.imm));
        check("imm_size", 32'(imm_size), 32'(exp.imm_size));
        check("disp", 32'(disp), 32'(exp.disp));
        check("disp_size", 32'(disp_size), 32'(exp.disp_size));
        check("base", 32'(ea_base_reg), 32'(exp.base));
        check("index", 32'(ea_index_reg), 32'(exp.index));
        check("seg", 32'(ea_segment_reg), 32'(exp.seg));
        check("length", 32'(length), 32'(exp.length));
        check("pop_in_valid", 32'(queue_pop), 0);
      end
    end
  end

  task automatic tick();
    logic [7:0] dummy;
    queue_valid = (feed.size() > 0) && !stall;
    queue_byte  = (feed.size() > 0) ? feed[0] : 8'h00;
    @(negedge clk);
    popped = queue_pop;
    @(posedge clk);
    if (popped) begin
      dummy = feed.pop_front();
      last_pop_cyc = cyc;
      npop++;
    end
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [7:0] q[$], input bit preload);
    exp = model(q);
    exp_armed = 1;
    if (!preload) foreach (q[k]) feed.push_back(q[k]);
  endtask

  task automatic run(input int stall_after, input int stall_len);
    int n = 0, stalled = 0;
    npop = 0;
    while (!decode_valid && n < 80) begin
      stall = (npop == stall_after) && (stalled < stall_len);
      if (stall) stalled++;
      tick();
      n++;
    end
    stall = 0;
    check("valid_timeout", 32'(decode_valid), 1);
    check("latency", 32'(cyc - last_pop_cyc), 1);
    check("pop_count", 32'(npop), 32'(exp.nbytes));
  endtask

  task automatic do_accept();
    accept = 1;
    tick();
    accept = 0;
    exp_armed = 0;
    check("valid_drop", 32'(decode_valid), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1; flush = 0; accept = 0; queue_valid = 0; queue_byte = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    check("rst_valid", 32'(decode_valid), 0);
    check("rst_src", 32'(src_operand), 32'hF);
    check("rst_dst", 32'(dst_operand), 32'hF);
    check("rst_base", 32'(ea_base_reg), 32'h8);
    check("rst_index", 32'(ea_index_reg), 32'h8);
    check("rst_seg", 32'(ea_segment_reg), 32'h3);
    check("rst_length", 32'(length), 0);
    check("rst_opcode", 32'(opcode), 0);

    q = {8'h8B, 8'h46, 8'hFE};
    issue(q, 0); run(-1, 0);
    check("t1_src", 32'(src_operand), 32'h8);
    check("t1_dst", 32'(dst_operand), 32'h0);
    check("t1_mod_rm", {27'd0, mod, rm}, 32'b01110);
    check("t1_disp", 32'(disp), 32'h00FE);
    check("t1_base", 32'(ea_base_reg), 32'h5);
    check("t1_seg", 32'(ea_segment_reg), 32'h2);
    check("t1_len", 32'(length), 32'h3);
    // Hold with the next instruction already waiting in the queue
    feed.push_back(8'hB4); feed.push_back(8'h12);
    repeat (5) begin
      tick();
      check("hold_no_pop", 32'(popped), 0);
    end
    check("hold_queue", 32'(feed.size()), 2);
    do_accept();

    q = {8'hB4, 8'h12};
    issue(q, 1); run(-1, 0);
    check("t2_dst", 32'(dst_operand), 32'h4);
    check("t2_word", 32'(word), 0);
    check("t2_imm", 32'(imm), 32'h0012);
    check("t2_len", 32'(length), 32'h2);
    do_accept();

    q = {8'h2E, 8'hC7, 8'h06, 8'h34, 8'h12, 8'h78, 8'h56};
    issue(q, 0); run(-1, 0);
    check("t3_seg", 32'(ea_segment_reg), 32'h1);
    check("t3_disp", 32'(disp), 32'h1234);
    check("t3_imm", 32'(imm), 32'h5678);
    check("t3_src_dst", {24'd0, src_operand, dst_operand}, 32'h98);
    check("t3_len", 32'(length), 32'h7);
    do_accept();

    q = {8'h05, 8'h34, 8'h12};
    issue(q, 0); run(1, 3);
    check("t4_dst", 32'(dst_operand), 32'h0);
    check("t4_imm", 32'(imm), 32'h1234);
    check("t4_len", 32'(length), 32'h3);
    do_accept();

    exp_armed = 0;
    feed.push_back(8'h2E); feed.push_back(8'h8B); feed.push_back(8'h90);
    tick(); tick();
    flush = 1;
    tick();
    check("flush_no_pop", 32'(popped), 0);
    flush = 0;
    q = {8'h90};
    issue(q, 1); run(-1, 0);
    check("t5_src_dst", {24'd0, src_operand, dst_operand}, 32'hFF);
    check("t5_seg", 32'(ea_segment_reg), 32'h3);
    check("t5_len", 32'(length), 32'h1);
    do_accept();

    q = {8'h26, 8'h36, 8'h01, 8'h87, 8'h34, 8'h12};
    issue(q, 0); run(-1, 0); do_accept();
    q = {8'h80, 8'hC3, 8'h55};
    issue(q, 0); run(-1, 0); do_accept();
    q = {8'h02, 8'h02};
    issue(q, 0); run(-1, 0); do_accept();
    q = {8'h83, 8'h43, 8'hFF, 8'h7F};
    issue(q, 0); run(-1, 0); do_accept();
    q = {8'hF4};
    issue(q, 0); run(-1, 0); do_accept();

    q = {};
    repeat (15) q.push_back(8'h3E);
    q.push_back(8'h90);
    issue(q, 0); run(-1, 0);
    check("sat_len", 32'(length), 32'hF);
    do_accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
